// File: rtl/debug_pkg.sv
// Shared constants and types for the debug dump sequencer: dump selectors,
// FSM state encoding, the ready byte and per-latch byte counts.
package debug_pkg;

  localparam logic [2:0] SEL_REGS   = 3'd0;
  localparam logic [2:0] SEL_IF_ID  = 3'd1;
  localparam logic [2:0] SEL_ID_EX  = 3'd2;
  localparam logic [2:0] SEL_EX_MEM = 3'd3;
  localparam logic [2:0] SEL_MEM_WB = 3'd4;
  localparam logic [2:0] SEL_MEM    = 3'd5;

  localparam logic [7:0] READY_BYTE = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SNAP,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_READY,
    S_WAIT_R,
    S_DONE
  } state_e;

  function automatic int bytes_of(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int IF_ID_BYTES  = bytes_of(64);
  localparam int ID_EX_BYTES  = bytes_of(129);
  localparam int EX_MEM_BYTES = bytes_of(78);
  localparam int MEM_WB_BYTES = bytes_of(72);

endpackage

// File: rtl/debug_dump_sequencer.sv
// Streams pipeline latches, the register file or data memory out through uart_tx,
// always ending with the ready byte. Data memory dumps need DEBUG_MEM_DUMP_EN.
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int MEM_SIZE      = 64,
  parameter int ADDR_WIDTH    = $clog2(MEM_SIZE),
  parameter int IF_ID_SIZE    = 64,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 78,
  parameter int MEM_WB_SIZE   = 72
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_req,
  input  logic [2:0]                       i_sel,
  input  logic [IF_ID_SIZE-1:0]            i_if_id,
  input  logic [ID_EX_SIZE-1:0]            i_id_ex,
  input  logic [EX_MEM_SIZE-1:0]           i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0]           i_mem_wb,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_reg_addr,
  input  logic [SIZE-1:0]                  i_reg_data,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  input  logic [SIZE-1:0]                  i_mem_data,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_start,
  input  logic                             i_tx_done,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int BPW      = SIZE / 8;
  localparam int RA_W     = $clog2(NUM_REGISTERS);
  localparam int BIW_W    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int SHADOW_W = max2(max2(max2(IF_ID_SIZE, ID_EX_SIZE),
                                      max2(EX_MEM_SIZE, MEM_WB_SIZE)), SIZE);
  localparam int IF_ID_B  = bytes_of(IF_ID_SIZE);
  localparam int ID_EX_B  = bytes_of(ID_EX_SIZE);
  localparam int EX_MEM_B = bytes_of(EX_MEM_SIZE);
  localparam int MEM_WB_B = bytes_of(MEM_WB_SIZE);
  localparam int REG_B    = NUM_REGISTERS * BPW;
`ifdef DEBUG_MEM_DUMP_EN
  localparam int CNT_W    = 9;
  localparam int IDX_W    = max2(RA_W, ADDR_WIDTH);
  localparam int MEM_B    = MEM_SIZE * BPW;
`else
  localparam int CNT_W    = 8;
  localparam int IDX_W    = RA_W;
`endif

  state_e              state, state_nxt;
  logic [2:0]          sel;
  logic [SHADOW_W-1:0] shadow;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [BIW_W-1:0]    biw;
  logic                word_dump;
  logic                word_end;
  logic [SIZE-1:0]     rd_word;

`ifdef DEBUG_MEM_DUMP_EN
  assign word_dump  = (sel == SEL_REGS) || (sel == SEL_MEM);
  assign rd_word    = (sel == SEL_MEM) ? i_mem_data : i_reg_data;
  assign o_mem_addr = (state == S_FETCH && sel == SEL_MEM) ? idx[ADDR_WIDTH-1:0] : '0;
`else
  logic unused_mem;
  assign unused_mem = ^i_mem_data;
  assign word_dump  = (sel == SEL_REGS);
  assign rd_word    = i_reg_data;
  assign o_mem_addr = '0;
`endif

  assign o_reg_addr = (state == S_FETCH && sel == SEL_REGS) ? idx[RA_W-1:0] : '0;
  assign word_end   = word_dump && (biw == BIW_W'(BPW - 1));
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_tx_start = 1'b0;
    o_tx_data  = '0;
    o_done     = 1'b0;
    case (state)
      S_IDLE:   if (i_req) state_nxt = S_SNAP;
      S_SNAP: begin
        case (sel)
          SEL_IF_ID, SEL_ID_EX, SEL_EX_MEM, SEL_MEM_WB: state_nxt = S_SEND;
          SEL_REGS:                                     state_nxt = S_FETCH;
`ifdef DEBUG_MEM_DUMP_EN
          SEL_MEM:                                      state_nxt = S_FETCH;
`endif
          default:                                      state_nxt = S_READY;
        endcase
      end
      S_FETCH:  state_nxt = S_SEND;
      S_SEND: begin
        o_tx_data  = shadow[7:0];
        o_tx_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        o_tx_data = shadow[7:0];
        if (i_tx_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        // cnt still holds the pre-decrement value here
        if (cnt == CNT_W'(1)) state_nxt = S_READY;
        else if (word_end)    state_nxt = S_FETCH;
        else                  state_nxt = S_SEND;
      end
      S_READY: begin
        o_tx_data  = READY_BYTE;
        o_tx_start = 1'b1;
        state_nxt  = S_WAIT_R;
      end
      S_WAIT_R: begin
        o_tx_data = READY_BYTE;
        if (i_tx_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel    <= '0;
      shadow <= '0;
      cnt    <= '0;
      idx    <= '0;
      biw    <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_req) sel <= i_sel;
        S_SNAP: begin
          idx    <= '0;
          biw    <= '0;
          shadow <= '0;
          cnt    <= '0;
          case (sel)
            SEL_IF_ID:  begin shadow <= SHADOW_W'(i_if_id);  cnt <= CNT_W'(IF_ID_B);  end
            SEL_ID_EX:  begin shadow <= SHADOW_W'(i_id_ex);  cnt <= CNT_W'(ID_EX_B);  end
            SEL_EX_MEM: begin shadow <= SHADOW_W'(i_ex_mem); cnt <= CNT_W'(EX_MEM_B); end
            SEL_MEM_WB: begin shadow <= SHADOW_W'(i_mem_wb); cnt <= CNT_W'(MEM_WB_B); end
            SEL_REGS:   cnt <= CNT_W'(REG_B);
`ifdef DEBUG_MEM_DUMP_EN
            SEL_MEM:    cnt <= CNT_W'(MEM_B);
`endif
            default:    cnt <= '0;
          endcase
        end
        S_FETCH: begin
          shadow <= SHADOW_W'(rd_word);
          biw    <= '0;
        end
        S_NEXT: begin
          shadow <= shadow >> 8;
          cnt    <= cnt - CNT_W'(1);
          if (word_end) begin
            idx <= idx + IDX_W'(1);
            biw <= '0;
          end else begin
            biw <= biw + BIW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: table of dumps plus hand-written corner sequences,
// with a uart_tx responder that checks every transmitted byte against a scoreboard.
module tb_debug_dump_sequencer;
  import debug_pkg::*;

`ifdef DEBUG_MEM_DUMP_EN
  localparam int MEM_BYTES = 256;
  localparam int MEM_LAT   = 3;
`else
  localparam int MEM_BYTES = 0;
  localparam int MEM_LAT   = 2;
`endif

  logic         clk;
  logic         rst;
  logic         req;
  logic [2:0]   sel;
  logic [63:0]  if_id;
  logic [128:0] id_ex;
  logic [77:0]  ex_mem;
  logic [71:0]  mem_wb;
  logic [4:0]   reg_addr;
  logic [31:0]  reg_data;
  logic [5:0]   mem_addr;
  logic [31:0]  mem_data;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done;
  logic         busy;
  logic         done;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;

  typedef struct {
    logic [2:0]   sel;
    logic [128:0] val;
    int           n;
    int           lat0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   ref_cyc    = 0;
  int   countdown  = 0;
  int   done_cnt   = 0;
  int   tx_cnt     = 0;

  function automatic logic [31:0] reg_val(input int i);
    return 32'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] mem_val(input int a);
    return (32'(a) * 32'h0001_0203) ^ 32'hC0DE_5A00;
  endfunction

  assign reg_data = reg_val(int'(reg_addr));
  assign mem_data = mem_val(int'(mem_addr));

  debug_dump_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_sel      (sel),
    .i_if_id    (if_id),
    .i_id_ex    (id_ex),
    .i_ex_mem   (ex_mem),
    .i_mem_wb   (mem_wb),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // uart_tx stand-in: scores each start, answers with tx_done after 1..3 cycles
  initial begin
    exp_t e;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done) tx_done = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          tx_done = 1'b1;
          ref_cyc = cyc;
          done_cnt++;
        end
      end
      if (tx_start) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: byte 0x%0h, want no transmission", tx_data);
        end else begin
          e = sb.pop_front();
          check("tx_byte", tx_data, e.data);
          check("tx_latency", cyc - ref_cyc, e.lat);
        end
        tx_cnt++;
        countdown = 1 + (tx_cnt % 3);
      end
    end
  end

  task automatic push_dump(input logic [2:0] s, input logic [128:0] v, input int n, input int lat0);
    exp_t        e;
    logic [31:0] w;
    bit          word;
    word = (s == SEL_REGS) || (s == SEL_MEM && MEM_BYTES > 0);
    for (int k = 0; k < n; k++) begin
      if (word) begin
        w = (s == SEL_REGS) ? reg_val(k / 4) : mem_val(k / 4);
        e.data = w[8*(k%4) +: 8];
      end else begin
        e.data = v[8*k +: 8];
      end
      e.lat = (k == 0) ? lat0 : ((word && (k % 4 == 0)) ? 3 : 2);
      sb.push_back(e);
    end
    e.data = 8'h52;
    e.lat  = (n == 0) ? lat0 : 2;
    sb.push_back(e);
  endtask

  task automatic start_req(input logic [2:0] s);
    @(negedge clk);
    sel     = s;
    req     = 1'b1;
    ref_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no o_done after %0d cycles, want a pulse", name, t);
      sb.delete();
      countdown = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check({name, "_done_lat"}, cyc - ref_cyc, 1);
      check({name, "_sb_empty"}, sb.size(), 0);
      @(negedge clk);
      check({name, "_busy_after"}, busy, 0);
      check({name, "_done_width"}, done, 0);
    end
  endtask

  task automatic set_latches(input logic [2:0] s, input logic [128:0] v);
    if_id  = 64'hDEAD_BEEF_0BAD_F00D;
    id_ex  = {1'b1, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA};
    ex_mem = 78'h2F_EEEE_DDDD_CCCC_BBBB_AA;
    mem_wb = 72'h77_6666_5555_4444_3333;
    case (s)
      SEL_IF_ID:  if_id  = v[63:0];
      SEL_ID_EX:  id_ex  = v;
      SEL_EX_MEM: ex_mem = v[77:0];
      SEL_MEM_WB: mem_wb = v[71:0];
      default: ;
    endcase
  endtask

  initial begin
    int base;
    int t;
    vecs[0] = '{sel: 3'd3, val: 129'(78'h3A_1122_3344_5566_7788_99), n: 10, lat0: 2};
    vecs[1] = '{sel: 3'd1, val: 129'(64'h0123_4567_89AB_CDEF), n: 8, lat0: 2};
    vecs[2] = '{sel: 3'd4, val: 129'(72'hC3_F0E1_D2C3_B4A5_9687), n: 9, lat0: 2};
    vecs[3] = '{sel: 3'd2, val: {1'b0, 128'hF00D_CAFE_1234_5678_9ABC_DEF0_0102_0304}, n: 17, lat0: 2};
    vecs[4] = '{sel: 3'd0, val: '0, n: 128, lat0: 3};
    vecs[5] = '{sel: 3'd7, val: '0, n: 0, lat0: 2};
    vecs[6] = '{sel: 3'd6, val: '0, n: 0, lat0: 2};
    vecs[7] = '{sel: 3'd5, val: '0, n: MEM_BYTES, lat0: MEM_LAT};

    rst = 1'b1;
    req = 1'b0;
    sel = '0;
    set_latches(3'd7, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_latches(vecs[i].sel, vecs[i].val);
      push_dump(vecs[i].sel, vecs[i].val, vecs[i].n, vecs[i].lat0);
      start_req(vecs[i].sel);
      check("busy_during", busy, 1);
      wait_done($sformatf("vec%0d", i));
    end

    // snapshot: latch cleared after SNAP must not alter the dump
    set_latches(3'd2, {1'b1, {16{8'hA5}}});
    push_dump(3'd2, {1'b1, {16{8'hA5}}}, 17, 2);
    start_req(3'd2);
    @(negedge clk);
    id_ex = '0;
    wait_done("snapshot");

    // a request while busy is dropped
    set_latches(3'd4, 129'(72'h18_2736_4554_6372_8190));
    push_dump(3'd4, 129'(72'h18_2736_4554_6372_8190), 9, 2);
    start_req(3'd4);
    repeat (3) @(negedge clk);
    sel = 3'd1;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("ignored_req");
    set_latches(3'd1, 129'(64'hFEDC_BA98_7654_3210));
    push_dump(3'd1, 129'(64'hFEDC_BA98_7654_3210), 8, 2);
    start_req(3'd1);
    wait_done("after_ignored");

    // reset mid-dump after the third byte completes; req alongside rst is ignored
    set_latches(3'd1, 129'(64'h1111_2222_3333_4444));
    push_dump(3'd1, 129'(64'h1111_2222_3333_4444), 8, 2);
    base = done_cnt;
    start_req(3'd1);
    t = 0;
    while (done_cnt < base + 3 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("mid_rst_reached", done_cnt - base, 3);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1;
    sel = 3'd1;
    sb.delete();
    countdown = 0;
    @(negedge clk);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("rst_beats_req", busy, 0);
    repeat (4) @(negedge clk);
    set_latches(3'd1, 129'(64'h1111_2222_3333_4444));
    push_dump(3'd1, 129'(64'h1111_2222_3333_4444), 8, 2);
    start_req(3'd1);
    wait_done("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Sequences the debug UART transmitter for state dumps. It takes a dump request from the debug command decoder, snapshots the selected pipeline latch, or walks the register file or data memory. It then streams the contents byte-by-byte through the `uart_tx` handshake and terminates every dump with the ready byte `'R'` (0x52). It sits between the `mips` debug command FSM and `uart_tx`, and is the only driver of `uart_tx` during dumps.

## Interface
Parameters:
- `SIZE`, 32, register/memory word width (bytes per word = SIZE/8).
- `NUM_REGISTERS`, 32, registers walked by a register dump.
- `MEM_SIZE`, 64, data memory words walked by a memory dump.
- `ADDR_WIDTH`, $clog2(MEM_SIZE), memory address width.
- `IF_ID_SIZE`, 64; `ID_EX_SIZE`, 129; `EX_MEM_SIZE`, 78; `MEM_WB_SIZE`, 72: latch widths.

Ports:
- `i_clk`, in, 1, clock.
- `i_rst`, in, 1, synchronous active-high reset.
- `i_req`, in, 1, dump request, one-cycle pulse.
- `i_sel`, in, 3, dump selector: 0 regs, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 data memory, 6–7 ready-only.
- `i_if_id` / `i_id_ex` / `i_ex_mem` / `i_mem_wb`, in, latch widths, live pipeline latches.
- `o_reg_addr`, out, $clog2(NUM_REGISTERS), register file debug read address.
- `i_reg_data`, in, SIZE, register read data (combinational read).
- `o_mem_addr`, out, ADDR_WIDTH, data memory debug read address.
- `i_mem_data`, in, SIZE, memory read data (combinational read).
- `o_tx_data`, out, 8, byte to transmit.
- `o_tx_start`, out, 1, `uart_tx` start pulse.
- `i_tx_done`, in, 1, `uart_tx` byte-complete pulse.
- `o_busy`, out, 1, dump in progress.
- `o_done`, out, 1, one-cycle pulse after `'R'` completes.

## Operation
- States: IDLE, SNAP, FETCH, SEND, WAIT, NEXT, READY, WAIT_R, DONE.
- IDLE, `i_req`=1:
  - Latch `i_sel` → SNAP.
  - `i_req` outside IDLE is ignored; requests are not queued.
- SNAP, latch selectors 1–4:
  - Copy the selected latch into a 129-bit shadow register, zero-extended.
  - Byte count = ceil(width/8): IF/ID 8, ID/EX 17, EX/MEM 10, MEM/WB 9.
  - → SEND.
- SNAP, selectors 0 and 5:
  - Word index = 0; byte count = NUM_REGISTERS×SIZE/8 or MEM_SIZE×SIZE/8.
  - → FETCH.
- SNAP, selectors 6–7: → READY.
- FETCH:
  - Drive address = word index; capture the read data into the low SIZE bits of the shadow register.
  - → SEND.
- SEND:
  - `o_tx_data` = shadow[7:0]; pulse `o_tx_start` one cycle.
  - → WAIT.
- WAIT:
  - Hold `o_tx_data` stable; on `i_tx_done` → NEXT.
- NEXT:
  - Shift the shadow register right 8 and decrement the byte counter.
  - Counter = 0 → READY.
  - Otherwise, word dump on a word boundary → FETCH with index+1; else → SEND.
- Byte order is LSB-first within each latch or word; words go in ascending index.
- READY: `o_tx_data`=0x52, pulse `o_tx_start` → WAIT_R.
- WAIT_R: on `i_tx_done` → DONE.
- DONE: pulse `o_done` → IDLE.
- `i_tx_done` outside WAIT/WAIT_R is ignored.
- Byte counter is 9 bits; counts up to 256 bytes (MEM_SIZE=64).

## Timing
- Reset values: all outputs 0, state IDLE, shadow and counters 0.
- `o_busy` = 1 in every state except IDLE.
- First `o_tx_start` timing after the `i_req` cycle:
  - Latch dumps: 2 cycles.
  - Reg/mem dumps: 3 cycles.
  - Selectors 6–7: 2 cycles.
- Between bytes:
  - Next `o_tx_start` comes 2 cycles after `i_tx_done`.
  - 3 cycles when crossing a word boundary.
- The snapshot is taken in SNAP; latch changes after that cycle do not affect the dump.
- Reset mid-dump: next cycle is IDLE with all outputs 0; no partial `'R'`; the next request restarts at byte 0.
- `i_req` in the same cycle as `i_rst`: reset wins.

## Configuration
- `DEBUG_MEM_DUMP_EN` defined:
  - Selector 5 dumps data memory.
  - `o_mem_addr`/`i_mem_data` are functional.
- Not defined:
  - Selector 5 behaves as ready-only.
  - `o_mem_addr` is tied 0 and `i_mem_data` is unused.
  - The byte counter may shrink to 8 bits.

## Structure
- Shared package `debug_pkg`:
  - Dump selector constants.
  - State enum.
  - `READY_BYTE` = 8'h52.
  - Per-latch byte-count constants derived from the latch widths.
- Single module. The shadow shift register is inline; no sub-module.

## Test plan
- EX/MEM dump, `i_ex_mem`=78'h3A_1122_3344_5566_7788_99 → bytes 99 88 77 66 55 44 33 22 11 3A, then 52; `o_done` pulse; `o_busy` falls.
- Register dump, reg[i]=i×0x01010101 → 128 bytes 00 00 00 00 01 01 01 01 … 1F 1F 1F 1F, then 52.
- ID/EX snapshot: change `i_id_ex` from all-0xA5 to all-0 one cycle after SNAP → 16×A5, 01, 52 (bit 128=1).
- `i_req` sel=1 pulsed during an active sel=4 dump → only 9 MEM/WB bytes + 52; a following sel=1 request → 8 bytes + 52.
- Reset after the third `i_tx_done` of an IF/ID dump → `o_tx_start`/`o_busy` 0 next cycle; a new sel=1 request restarts at byte 0.
- sel=7 → single 52 byte, first `o_tx_start` 2 cycles after `i_req`.
- sel=5 with the macro defined → 256 bytes + 52; without it → only 52.
